// File: rtl/fg_line_eval_pkg.sv
// Shared definitions for the foreground per-line object evaluator.
// Contents: scan FSM state type, OBM Y-byte offset, object height and the
// 9-bit (non-wrapping) line/object intersection test.
package fg_line_eval_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } state_e;

  // Byte 1 of each 4-byte OBM entry holds the object's Y position.
  localparam logic [1:0] OBM_Y_OFFSET = 2'd1;

  // Fixed by the pattern format.
  localparam int unsigned OBJ_HEIGHT = 8;

  // Objects near the bottom must not wrap to the top lines, so compare in 9 bits.
  function automatic logic obj_hit(input logic [7:0] obj_y, input logic [7:0] line_y);
    logic [8:0] top;
    logic [8:0] bot;
    logic [8:0] y9;
    top = {1'b0, obj_y};
    bot = top + 9'(OBJ_HEIGHT);
    y9  = {1'b0, line_y};
    return (top <= y9) && (y9 < bot);
  endfunction

endpackage

// File: rtl/fg_line_eval_slot_bank.sv
// fg_slot_bank: one bank of the double-buffered per-line object list.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clear_i        - empty the bank (count, slots and overflow to 0); wins over the others
//   append_i       - write obma_i into the next free slot (ignored when full)
//   obma_i         - object index to append
//   set_ovf_i      - set the sticky overflow flag
//   obma_o         - slot k at [6k +: 6]; unused slots read 0
//   count_o        - number of valid slots
//   overflow_o     - sticky overflow flag
module fg_slot_bank #(
  parameter int unsigned MaxPerLine = 8,
  parameter int unsigned CntW       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    append_i,
  input  logic [5:0]              obma_i,
  input  logic                    set_ovf_i,
  output logic [6*MaxPerLine-1:0] obma_o,
  output logic [CntW-1:0]         count_o,
  output logic                    overflow_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxPerLine);

  logic [6*MaxPerLine-1:0] obma_q, obma_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    ovf_q, ovf_d;

  always_comb begin
    obma_d  = obma_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      obma_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (append_i && (count_q != MaxCnt)) begin
        for (int unsigned k = 0; k < MaxPerLine; k++) begin
          if (count_q == CntW'(k)) obma_d[6*k +: 6] = obma_i;
        end
        count_d = count_q + 1'b1;
      end
      if (set_ovf_i) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      obma_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      obma_q  <= obma_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign obma_o     = obma_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/foreground_line_eval.sv
// foreground_line_eval: scans OBM Y bytes during each line and builds the
// priority-ordered (ascending OBMA) list of objects hitting the next line.
// Two fg_slot_bank instances are ping-ponged by sel_q: the display bank is
// stable for a whole line while the other one is being filled.
// Ports:
//   clk_12_5875, rst         - pixel clock, asynchronous active-low reset
//   line_start, next_y       - per-line pulse (swap banks, start scan) and line to evaluate
//   obm_rd_en, obm_addr      - OBM Y-byte read request; obm_data returns one cycle later
//   disp_obma/count/overflow - display bank contents
//   busy                     - scan in progress (SCAN or DRAIN)
//   overflow_lines           - only with FG_LINE_EVAL_STATS_EN: saturating per-frame
//                              count of lines shown with overflow set
module foreground_line_eval
  import fg_line_eval_pkg::*;
#(
  parameter int unsigned NUM_OBJECTS  = 64,
  parameter int unsigned MAX_PER_LINE = 8
) (
  input  logic                              clk_12_5875,
  input  logic                              rst,
  input  logic                              line_start,
  input  logic [7:0]                        next_y,
  output logic                              obm_rd_en,
  output logic [7:0]                        obm_addr,
  input  logic [7:0]                        obm_data,
  output logic [6*MAX_PER_LINE-1:0]         disp_obma,
  output logic [$clog2(MAX_PER_LINE+1)-1:0] disp_count,
  output logic                              disp_overflow,
`ifdef FG_LINE_EVAL_STATS_EN
  output logic [7:0]                        overflow_lines,
`endif
  output logic                              busy
);

  localparam int unsigned     CntW    = $clog2(MAX_PER_LINE + 1);
  localparam logic [5:0]      LastIdx = 6'(NUM_OBJECTS - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_PER_LINE);

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] cmp_idx_q, cmp_idx_d;
  logic       cmp_valid_q, cmp_valid_d;
  logic [7:0] y_q, y_d;
  logic       sel_q, sel_d;  // index of the display bank

  logic [6*MAX_PER_LINE-1:0] bank_obma [2];
  logic [CntW-1:0]           bank_cnt  [2];
  logic                      bank_ovf  [2];
  logic                      disp_clear, eval_append, eval_set_ovf;
  logic                      hit, eval_full, aborting;
  logic [CntW-1:0]           eval_count;
  logic                      eval_ovf;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fg_slot_bank #(
      .MaxPerLine(MAX_PER_LINE),
      .CntW      (CntW)
    ) u_bank (
      .clk_i     (clk_12_5875),
      .rst_ni    (rst),
      .clear_i   (disp_clear & (sel_q == 1'(b))),
      .append_i  (eval_append & (sel_q != 1'(b))),
      .obma_i    (cmp_idx_q),
      .set_ovf_i (eval_set_ovf & (sel_q != 1'(b))),
      .obma_o    (bank_obma[b]),
      .count_o   (bank_cnt[b]),
      .overflow_o(bank_ovf[b])
    );
  end

  assign eval_count = sel_q ? bank_cnt[0] : bank_cnt[1];
  assign eval_ovf   = sel_q ? bank_ovf[0] : bank_ovf[1];
  assign eval_full  = (eval_count == MaxCnt);
  assign hit        = cmp_valid_q && obj_hit(obm_data, y_q);
  assign aborting   = line_start && ((state_q == StScan) || (state_q == StDrain));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cmp_idx_d    = idx_q;
    cmp_valid_d  = 1'b0;
    y_d          = y_q;
    sel_d        = sel_q;
    disp_clear   = 1'b0;
    eval_append  = 1'b0;
    eval_set_ovf = 1'b0;
    if (line_start) begin
      // The old display bank becomes the new eval bank; the in-flight compare is dropped.
      sel_d        = ~sel_q;
      disp_clear   = 1'b1;
      eval_set_ovf = aborting;
      y_d          = next_y;
      idx_d        = '0;
      state_d      = StScan;
    end else begin
      unique case (state_q)
        StScan: begin
          cmp_valid_d = 1'b1;
          idx_d       = idx_q + 6'd1;
          if (idx_q == LastIdx) state_d = StDrain;
        end
        StDrain: state_d = StDone;
        default: ;
      endcase
      if (hit) begin
        if (eval_full) begin
          // Stop at once: no further reads, discard the compare already in flight.
          eval_set_ovf = 1'b1;
          cmp_valid_d  = 1'b0;
          state_d      = StDone;
        end else begin
          eval_append = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_12_5875 or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cmp_idx_q   <= '0;
      cmp_valid_q <= 1'b0;
      y_q         <= '0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cmp_idx_q   <= cmp_idx_d;
      cmp_valid_q <= cmp_valid_d;
      y_q         <= y_d;
      sel_q       <= sel_d;
    end
  end

  assign obm_rd_en     = (state_q == StScan);
  assign obm_addr      = obm_rd_en ? {idx_q, OBM_Y_OFFSET} : 8'd0;
  assign busy          = (state_q == StScan) || (state_q == StDrain);
  assign disp_obma     = sel_q ? bank_obma[1] : bank_obma[0];
  assign disp_count    = sel_q ? bank_cnt[1] : bank_cnt[0];
  assign disp_overflow = sel_q ? bank_ovf[1] : bank_ovf[0];

`ifdef FG_LINE_EVAL_STATS_EN
  logic [7:0] ovf_lines_q, ovf_lines_d, ovf_base;

  // A frame restart (next_y == 0) clears first, then the swapped-in line still counts.
  always_comb begin
    ovf_base    = ovf_lines_q;
    ovf_lines_d = ovf_lines_q;
    if (line_start) begin
      if (next_y == 8'd0) ovf_base = 8'd0;
      ovf_lines_d = ovf_base;
      if ((eval_ovf || aborting) && (ovf_base != 8'hFF)) ovf_lines_d = ovf_base + 8'd1;
    end
  end

  always_ff @(posedge clk_12_5875 or negedge rst) begin
    if (!rst) ovf_lines_q <= '0;
    else      ovf_lines_q <= ovf_lines_d;
  end

  assign overflow_lines = ovf_lines_q;
`endif

endmodule

// File: tb/tb_foreground_line_eval.sv
// Bench for foreground_line_eval: table-driven line evaluations checked via a
// scoreboard (expected bank pushed at line_start, compared when the next
// line_start swaps it to the display side), plus hand-written abort,
// reset-mid-scan and statistics sequences.
module tb_foreground_line_eval;

  localparam int unsigned NObj = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  next_y = 8'd0;
  logic        obm_rd_en;
  logic [7:0]  obm_addr;
  logic [7:0]  obm_data = 8'd0;
  logic [47:0] disp_obma;
  logic [3:0]  disp_count;
  logic        disp_overflow;
  logic        busy;
`ifdef FG_LINE_EVAL_STATS_EN
  logic [7:0]  overflow_lines;
`endif

  foreground_line_eval #(
    .NUM_OBJECTS (64),
    .MAX_PER_LINE(8)
  ) dut (
    .clk_12_5875  (clk),
    .rst          (rst_n),
    .line_start   (line_start),
    .next_y       (next_y),
    .obm_rd_en    (obm_rd_en),
    .obm_addr     (obm_addr),
    .obm_data     (obm_data),
    .disp_obma    (disp_obma),
    .disp_count   (disp_count),
    .disp_overflow(disp_overflow),
`ifdef FG_LINE_EVAL_STATS_EN
    .overflow_lines(overflow_lines),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // OBM model: synchronous read, data valid the cycle after obm_rd_en.
  logic [7:0] mem [NObj];
  always @(posedge clk) if (obm_rd_en) obm_data <= mem[obm_addr[7:2]];

  typedef struct packed {
    logic [3:0]  cnt;
    logic [47:0] obma;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0] ey;
    logic [7:0] bg;
    int         lo;
    int         hi;
    logic [7:0] fill;
    int         i0, i1, i2;
    logic [7:0] y0, y1, y2;
    exp_t       e;
    int         erd;
  } vec_t;

  exp_t sb_q [$];
  int   checks = 0;
  int   failures = 0;
  int   rd_cnt = 0;
  int   busy_cnt = 0;
  int   exp_idx = 0;
  int   proto_err = 0;

  // Read-protocol monitor: addresses in ascending order, reads only while busy.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (obm_rd_en) begin
      if (!busy || obm_addr != {exp_idx[5:0], 2'b01}) proto_err++;
      exp_idx++;
      rd_cnt++;
    end
  end

  function automatic logic [47:0] slots(input int s0 = 0, input int s1 = 0, input int s2 = 0,
                                        input int s3 = 0, input int s4 = 0, input int s5 = 0,
                                        input int s6 = 0, input int s7 = 0);
    return {6'(s7), 6'(s6), 6'(s5), 6'(s4), 6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  function automatic vec_t mkv(input logic [7:0] ey, input logic [7:0] bg, input int lo,
                               input int hi, input logic [7:0] fill, input int cnt,
                               input logic [47:0] ob, input bit ovf, input int erd,
                               input int i0 = -1, input logic [7:0] y0 = 0,
                               input int i1 = -1, input logic [7:0] y1 = 0,
                               input int i2 = -1, input logic [7:0] y2 = 0);
    vec_t v;
    v.ey = ey; v.bg = bg; v.lo = lo; v.hi = hi; v.fill = fill;
    v.i0 = i0; v.y0 = y0; v.i1 = i1; v.y1 = y1; v.i2 = i2; v.y2 = y2;
    v.e.cnt = 4'(cnt); v.e.obma = ob; v.e.ovf = ovf;
    v.erd = erd;
    return v;
  endfunction

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < NObj; i++) begin
      mem[i] = (i >= v.lo && i <= v.hi) ? v.fill : v.bg;
    end
    if (v.i0 >= 0) mem[v.i0] = v.y0;
    if (v.i1 >= 0) mem[v.i1] = v.y1;
    if (v.i2 >= 0) mem[v.i2] = v.y2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle line_start; afterwards the display bank must hold the oldest expectation.
  task automatic pulse_line(input logic [7:0] y);
    exp_t e;
    @(posedge clk); #1;
    line_start = 1'b1;
    next_y     = y;
    @(posedge clk); #1;
    line_start = 1'b0;
    rd_cnt = 0; busy_cnt = 0; exp_idx = 0; proto_err = 0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("disp_count", 64'(disp_count), 64'(e.cnt));
      check("disp_obma", 64'(disp_obma), 64'(e.obma));
      check("disp_overflow", 64'(disp_overflow), 64'(e.ovf));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    check("scan_timeout", 64'(busy), 64'd0);
  endtask

  task automatic check_reset(input string name);
    check(name, 64'({disp_count, disp_obma, disp_overflow, busy, obm_rd_en, obm_addr}), 64'd0);
  endtask

  initial begin
    vec_t tbl [9];
    vec_t v;

    tbl[0] = mkv(8'd12, 8'hC0, 1, 0, 8'd0, 2, slots(0, 2), 1'b0, 64,
                 0, 8'd12, 1, 8'd13, 2, 8'd5);
    tbl[1] = mkv(8'd40, 8'hC0, 0, 9, 8'd40, 8, slots(0, 1, 2, 3, 4, 5, 6, 7), 1'b1, 10);
    tbl[2] = mkv(8'hFF, 8'hC0, 1, 0, 8'd0, 2, slots(7, 20), 1'b0, 64, 7, 8'hF9, 20, 8'hFF);
    tbl[3] = mkv(8'hF8, 8'hC0, 1, 0, 8'd0, 0, slots(), 1'b0, 64, 7, 8'hF9, 20, 8'hFF);
    tbl[4] = mkv(8'd107, 8'hC0, 56, 63, 8'd100, 8, slots(56, 57, 58, 59, 60, 61, 62, 63),
                 1'b0, 64);
    tbl[5] = mkv(8'd108, 8'hC0, 56, 63, 8'd100, 0, slots(), 1'b0, 64);
    tbl[6] = mkv(8'd254, 8'hFF, 1, 0, 8'd0, 1, slots(63), 1'b0, 64, 63, 8'd250);
    tbl[7] = mkv(8'd0, 8'hC0, 1, 0, 8'd0, 0, slots(), 1'b0, 64);
    tbl[8] = mkv(8'd2, 8'hC0, 1, 0, 8'd0, 1, slots(9), 1'b0, 64,
                 1, 8'hFC, 9, 8'd0, 12, 8'd3);
    // The remaining fields of the trailing vector are unused.
    tbl[8].i2 = 12;
    mem[3] = 8'hC0;

    repeat (3) @(posedge clk);
    #1 check_reset("reset_outputs");
    rst_n = 1'b1;

    // Table-driven evaluations; the extra read 3 of mem is overwritten by load_mem.
    for (int i = 0; i < 9; i++) begin
      load_mem(tbl[i]);
      pulse_line(tbl[i].ey);
      sb_q.push_back(tbl[i].e);
      wait_done();
      check("rd_count", 64'(rd_cnt), 64'(tbl[i].erd));
      check("busy_cycles", 64'(busy_cnt), 64'(tbl[i].e.ovf ? tbl[i].erd : 65));
      check("rd_protocol", 64'(proto_err), 64'd0);
    end

    // Abort: a second line_start 20 cycles into a scan with hits at 5 and 30.
    v = mkv(8'd50, 8'hC0, 1, 0, 8'd0, 1, slots(5), 1'b1, 0, 5, 8'd50, 30, 8'd50);
    load_mem(v);
    pulse_line(8'd50);
    sb_q.push_back(v.e);
    repeat (19) @(posedge clk);
    pulse_line(8'd0);
    wait_done();

    // Reset in the middle of a scan.
    v = mkv(8'd20, 8'hC0, 1, 0, 8'd0, 2, slots(3, 10), 1'b0, 64, 3, 8'd20, 10, 8'd20);
    load_mem(v);
    pulse_line(8'd20);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset("reset_mid_scan");
    repeat (2) @(posedge clk);
    #1 check_reset("reset_held");
    rst_n = 1'b1;
    pulse_line(8'd20);
    check("post_reset_disp_count", 64'(disp_count), 64'd0);
    sb_q.push_back(v.e);
    wait_done();
    pulse_line(8'd20);
    wait_done();

`ifdef FG_LINE_EVAL_STATS_EN
    // Frame statistics: three overflow lines, then a frame restart on a clean line.
    load_mem(mkv(8'd0, 8'hC0, 1, 0, 8'd0, 0, slots(), 1'b0, 64));
    pulse_line(8'd0);
    wait_done();
    pulse_line(8'd0);
    wait_done();
    check("stats_start", 64'(overflow_lines), 64'd0);
    load_mem(tbl[1]);
    pulse_line(8'd40);
    wait_done();
    pulse_line(8'd40);
    wait_done();
    pulse_line(8'd40);
    wait_done();
    load_mem(tbl[7]);
    pulse_line(8'd40);
    check("stats_three", 64'(overflow_lines), 64'd3);
    wait_done();
    pulse_line(8'd0);
    check("stats_cleared", 64'(overflow_lines), 64'd0);
    wait_done();
`endif

    pulse_line(8'd0);
    wait_done();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
